eth_pkt_fifo: RTL and testbench

ETH_PKT_FIFO -- requirements
Module: eth_pkt_fifo

---
 rtl/eth_pkg.sv | 15 +
 rtl/eth_dpram.sv | 22 ++
 rtl/eth_pkt_fifo.sv | 139 +++++++++++++
 tb/tb_eth_pkt_fifo.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet packet FIFO: word layout, FSM encoding
// and the default destination address.
package eth_pkg;
  localparam int WORD_W  = 34;
  localparam int EOP_BIT = 33;
  localparam int SOP_BIT = 32;

  localparam logic [31:0] DEFAULT_PORT_ADDR = 32'h0000ABCD;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    DROP   = 2'd2
  } state_t;
endpackage

// File: rtl/eth_dpram.sv
// Packet storage: synchronous write port, asynchronous read port, contents
// are never reset.
module eth_dpram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 34,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/eth_pkt_fifo.sv
// Store-and-forward packet FIFO: packets addressed to PORT_ADDR are buffered
// and released only once their eop word is written; others are dropped.
//
// Read handshake: a word transfers on any rising edge where out_valid and
// out_ready are both 1; out_valid never depends on out_ready, and out_data
// is stable while out_valid is high and out_ready is low.
module eth_pkt_fifo
  import eth_pkg::*;
#(
  parameter int          DEPTH     = 16,
  parameter logic [31:0] PORT_ADDR = DEFAULT_PORT_ADDR
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_wr_en,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [4:0]        pkt_cnt,
  output logic [7:0]        drop_cnt,
  output logic              full,
  output state_t            fsmState
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] ONE      = PW'(1);
  localparam logic [PW-1:0] DEPTH_PW = PW'(DEPTH);

  state_t        state, nextState;
  logic [PW-1:0] wrPtr, cmtPtr, rdPtr;
  logic [PW-1:0] wrBase;
  logic          doWrite, doCommit, doRollback;
  logic [1:0]    dropAmt;
  logic          isSop, isEop, addrMatch, cmtFull, sopFull;
  logic          rdEn, rdEop;
  logic [8:0]    dropSum;

  assign isSop     = in_data[SOP_BIT];
  assign isEop     = in_data[EOP_BIT];
  assign addrMatch = (in_data[31:0] == PORT_ADDR);

  // full counts uncommitted words too; a read only frees space once rdPtr moves
  assign full    = ((wrPtr - rdPtr) == DEPTH_PW);
  assign cmtFull = ((cmtPtr - rdPtr) == DEPTH_PW);
  // a sop arriving in ACCEPT sees the occupancy left after rolling back
  assign sopFull = (state == ACCEPT) ? cmtFull : full;

  assign out_valid = (rdPtr != cmtPtr);
  assign rdEn      = out_valid & out_ready;
  assign rdEop     = rdEn & out_data[EOP_BIT];
  assign fsmState  = state;

  always_comb begin
    nextState  = state;
    doWrite    = 1'b0;
    doCommit   = 1'b0;
    doRollback = 1'b0;
    dropAmt    = 2'd0;
    if (in_wr_en) begin
      case (state)
        ACCEPT: begin
          if (isSop) begin
            doRollback = 1'b1;
            dropAmt    = 2'd1;
          end else if (full) begin
            doRollback = 1'b1;
            dropAmt    = 2'd1;
            nextState  = isEop ? IDLE : DROP;
          end else begin
            doWrite = 1'b1;
            if (isEop) begin
              doCommit  = 1'b1;
              nextState = IDLE;
            end
          end
        end
        DROP: begin
          if (!isSop && isEop) nextState = IDLE;
        end
        default: ;
      endcase

      // every sop, whatever the state, starts a fresh accept/drop decision
      if (isSop) begin
        if (addrMatch && !sopFull) begin
          doWrite = 1'b1;
          if (isEop) begin
            doCommit  = 1'b1;
            nextState = IDLE;
          end else begin
            nextState = ACCEPT;
          end
        end else begin
          dropAmt   = dropAmt + 2'd1;
          nextState = isEop ? IDLE : DROP;
        end
      end
    end
  end

  assign wrBase  = doRollback ? cmtPtr : wrPtr;
  assign dropSum = {1'b0, drop_cnt} + {7'd0, dropAmt};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      wrPtr    <= '0;
      cmtPtr   <= '0;
      rdPtr    <= '0;
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      state <= nextState;
      if (doWrite)         wrPtr <= wrBase + ONE;
      else if (doRollback) wrPtr <= cmtPtr;
      if (doCommit) cmtPtr <= wrBase + ONE;
      if (rdEn)     rdPtr  <= rdPtr + ONE;
      case ({doCommit, rdEop})
        2'b10:   pkt_cnt <= pkt_cnt + 5'd1;
        2'b01:   pkt_cnt <= pkt_cnt - 5'd1;
        default: ;
      endcase
      drop_cnt <= (dropSum > 9'd255) ? 8'd255 : dropSum[7:0];
    end
  end

  eth_dpram #(
    .DEPTH(DEPTH),
    .WIDTH(WORD_W)
  ) u_ram (
    .clk  (clk),
    .we   (doWrite),
    .waddr(wrBase[AW-1:0]),
    .wdata(in_data),
    .raddr(rdPtr[AW-1:0]),
    .rdata(out_data)
  );
endmodule

// File: tb/tb_eth_pkt_fifo.sv
// Directed bench for eth_pkt_fifo: hand-computed expectations checked with
// immediate assertions after each step.
module tb_eth_pkt_fifo;
  import eth_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        in_wr_en;
  logic [33:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [33:0] out_data;
  logic [4:0]  pkt_cnt;
  logic [7:0]  drop_cnt;
  logic        full;
  state_t      fsmState;

  int compared = 0;
  int mismatched = 0;

  eth_pkt_fifo #(.DEPTH(16), .PORT_ADDR(32'h0000ABCD)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_wr_en (in_wr_en),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .pkt_cnt  (pkt_cnt),
    .drop_cnt (drop_cnt),
    .full     (full),
    .fsmState (fsmState)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic eop, input logic sop, input logic [31:0] pl);
    in_wr_en = 1'b1;
    in_data  = {eop, sop, pl};
    step();
    in_wr_en = 1'b0;
    in_data  = '0;
  endtask

  logic [33:0] expA [4];
  logic [33:0] expE [3];

  initial begin
    in_wr_en  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    reset_n   = 1'b0;
    repeat (2) step();
    check("rst_out_valid", out_valid, 0);
    check("rst_full", full, 0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_state", fsmState, IDLE);
    reset_n = 1'b1;
    step();

    // non-sop word in IDLE is ignored
    send(1'b1, 1'b0, 32'h0000ABCD);
    check("idle_nosop_state", fsmState, IDLE);
    check("idle_nosop_valid", out_valid, 0);
    check("idle_nosop_drop", drop_cnt, 0);

    // 4-word accepted packet
    out_ready = 1'b1;
    expA[0] = {2'b01, 32'h0000ABCD};
    expA[1] = {2'b00, 32'h00001111};
    expA[2] = {2'b00, 32'h00002222};
    expA[3] = {2'b10, 32'h00003333};
    send(1'b0, 1'b1, 32'h0000ABCD);
    check("a_state_accept", fsmState, ACCEPT);
    check("a_valid_sop", out_valid, 0);
    send(1'b0, 1'b0, 32'h00001111);
    send(1'b0, 1'b0, 32'h00002222);
    check("a_valid_pre_eop", out_valid, 0);
    send(1'b1, 1'b0, 32'h00003333);
    check("a_valid_after_eop", out_valid, 1);
    check("a_pkt_cnt_1", pkt_cnt, 1);
    check("a_state_idle", fsmState, IDLE);
    for (int i = 0; i < 4; i++) begin
      check("a_word_valid", out_valid, 1);
      check("a_word_data", out_data, expA[i]);
      step();
    end
    check("a_drained_valid", out_valid, 0);
    check("a_pkt_cnt_0", pkt_cnt, 0);

    // mismatched address packet is dropped
    send(1'b0, 1'b1, 32'h0000BEEF);
    check("b_drop_cnt", drop_cnt, 1);
    check("b_state_drop", fsmState, DROP);
    send(1'b0, 1'b0, 32'h0000ABCD);
    send(1'b1, 1'b0, 32'h00000002);
    check("b_state_idle", fsmState, IDLE);
    check("b_valid", out_valid, 0);
    check("b_drop_cnt_end", drop_cnt, 1);

    // overflow: 10-word packet commits, 8-word packet rolls back
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++)
      send(i == 9, i == 0, (i == 0) ? 32'h0000ABCD : 32'h100 + i);
    check("c_pkt_cnt_1", pkt_cnt, 1);
    check("c_full_10", full, 0);
    for (int i = 0; i < 6; i++)
      send(1'b0, i == 0, (i == 0) ? 32'h0000ABCD : 32'h200 + i);
    check("c_full_16", full, 1);
    check("c_state_accept", fsmState, ACCEPT);
    send(1'b0, 1'b0, 32'h00000206);
    check("c_full_rollback", full, 0);
    check("c_drop_cnt", drop_cnt, 2);
    check("c_state_drop", fsmState, DROP);
    send(1'b1, 1'b0, 32'h00000207);
    check("c_state_idle", fsmState, IDLE);
    check("c_pkt_cnt_keep", pkt_cnt, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("c_word_valid", out_valid, 1);
      check("c_word_data", out_data,
            {(i == 9) ? 1'b1 : 1'b0, (i == 0) ? 1'b1 : 1'b0,
             (i == 0) ? 32'h0000ABCD : 32'h100 + i});
      step();
    end
    check("c_drained_valid", out_valid, 0);
    check("c_pkt_cnt_0", pkt_cnt, 0);

    // single-word packet
    send(1'b1, 1'b1, 32'h0000ABCD);
    check("d_valid", out_valid, 1);
    check("d_pkt_cnt_1", pkt_cnt, 1);
    check("d_data", out_data, {2'b11, 32'h0000ABCD});
    step();
    check("d_valid_0", out_valid, 0);
    check("d_pkt_cnt_0", pkt_cnt, 0);

    // new sop mid-packet abandons the first packet
    expE[0] = {2'b01, 32'h0000ABCD};
    expE[1] = {2'b00, 32'h000000B1};
    expE[2] = {2'b10, 32'h000000B2};
    send(1'b0, 1'b1, 32'h0000ABCD);
    send(1'b0, 1'b0, 32'h000000A1);
    send(1'b0, 1'b1, 32'h0000ABCD);
    check("e_drop_cnt", drop_cnt, 3);
    check("e_state_accept", fsmState, ACCEPT);
    check("e_valid_0", out_valid, 0);
    send(1'b0, 1'b0, 32'h000000B1);
    send(1'b1, 1'b0, 32'h000000B2);
    for (int i = 0; i < 3; i++) begin
      check("e_word_valid", out_valid, 1);
      check("e_word_data", out_data, expE[i]);
      step();
    end
    check("e_drained_valid", out_valid, 0);

    // mismatched sop mid-packet: abandon plus drop of the new packet
    send(1'b0, 1'b1, 32'h0000ABCD);
    send(1'b0, 1'b1, 32'h0000BEEF);
    check("f_drop_cnt", drop_cnt, 5);
    check("f_state_drop", fsmState, DROP);
    send(1'b1, 1'b0, 32'h00000000);
    check("f_state_idle", fsmState, IDLE);
    check("f_valid_0", out_valid, 0);

    // reset mid-packet with two packets committed
    out_ready = 1'b0;
    send(1'b0, 1'b1, 32'h0000ABCD);
    send(1'b1, 1'b0, 32'h00000001);
    send(1'b1, 1'b1, 32'h0000ABCD);
    send(1'b0, 1'b1, 32'h0000ABCD);
    send(1'b0, 1'b0, 32'h00000002);
    check("g_pkt_cnt_2", pkt_cnt, 2);
    check("g_state_accept", fsmState, ACCEPT);
    reset_n = 1'b0;
    step();
    check("g_rst_valid", out_valid, 0);
    check("g_rst_pkt_cnt", pkt_cnt, 0);
    check("g_rst_drop_cnt", drop_cnt, 0);
    check("g_rst_full", full, 0);
    check("g_rst_state", fsmState, IDLE);
    reset_n = 1'b1;
    step();

    // drop counter saturation
    for (int i = 0; i < 255; i++) send(1'b1, 1'b1, 32'h0000BEEF);
    check("h_drop_255", drop_cnt, 255);
    send(1'b1, 1'b1, 32'h0000BEEF);
    check("h_drop_sat", drop_cnt, 255);
    check("h_state_idle", fsmState, IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
